// File: rtl/mult_sequencer.sv
// Signed shift-and-add multiplication sequencer: the FSM, the iteration counter and the product accumulator.
// Latency is fixed and does not depend on the data. Outputs are Moore decodes of the state plus the held product register.
module mult_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic                 product_valid,
  output logic [2*WIDTH-1:0]   product,
  output logic                 add_en,
  output logic                 shift_en
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t               state_r;
  state_t               next_s;
  logic [WIDTH-1:0]     a_mag_r;
  logic [WIDTH-1:0]     b_mag_r;
  logic                 neg_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [2*WIDTH-1:0]   product_r;
  logic                 done_first_r;
  logic                 load_s;

  // Magnitude of a two's-complement operand; the most negative value maps onto 2^(WIDTH-1), which still fits.
  function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) begin
      abs_mag = ~v + WIDTH'(1);
    end else begin
      abs_mag = v;
    end
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] mag, input logic neg);
    if (neg) begin
      apply_sign = ~mag + (2*WIDTH)'(1);
    end else begin
      apply_sign = mag;
    end
  endfunction

  // New operands are accepted only from IDLE or DONE, and never while abort is asserted.
  assign load_s = start && !abort && ((state_r == S_IDLE) || (state_r == S_DONE));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic; abort overrides every other transition, start included.
  always_comb begin
    next_s = state_r;
    if (abort) begin
      next_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE:  next_s = start ? S_LOAD : S_IDLE;
        S_LOAD:  next_s = S_RUN;
        S_RUN:   next_s = (cnt_r == CNT_LAST) ? S_FIX : S_RUN;
        S_FIX:   next_s = S_DONE;
        S_DONE:  next_s = start ? S_LOAD : S_DONE;
        default: next_s = S_IDLE;
      endcase
    end
  end

  // Datapath: capture operands, accumulate the partial products, then sign the result once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_mag_r      <= {WIDTH{1'b0}};
      b_mag_r      <= {WIDTH{1'b0}};
      neg_r        <= 1'b0;
      acc_r        <= {(2*WIDTH){1'b0}};
      cnt_r        <= {CNT_W{1'b0}};
      product_r    <= {(2*WIDTH){1'b0}};
      done_first_r <= 1'b0;
    end else begin
      done_first_r <= (state_r == S_FIX);
      case (state_r)
        S_IDLE, S_DONE: begin
          if (load_s) begin
            a_mag_r <= abs_mag(multiplicand);
            b_mag_r <= abs_mag(multiplier);
            neg_r   <= multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
          end
        end
        S_LOAD: begin
          acc_r <= {(2*WIDTH){1'b0}};
          cnt_r <= {CNT_W{1'b0}};
        end
        S_RUN: begin
          if (b_mag_r[0]) begin
            acc_r <= acc_r + ({{WIDTH{1'b0}}, a_mag_r} << cnt_r);
          end
          b_mag_r <= b_mag_r >> 1;
          cnt_r   <= cnt_r + CNT_W'(1);
        end
        S_FIX: begin
          // An abort in FIX must leave the previously reported product intact.
          if (!abort) begin
            product_r <= apply_sign(acc_r, neg_r);
          end
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

  // Output decode from the registered state only.
  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    product_valid = 1'b0;
    add_en        = 1'b0;
    shift_en      = 1'b0;
    case (state_r)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_LOAD, S_FIX: begin
        busy = 1'b1;
      end
      S_RUN: begin
        busy     = 1'b1;
        shift_en = 1'b1;
        add_en   = b_mag_r[0];
      end
      S_DONE: begin
        product_valid = 1'b1;
        done          = done_first_r;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign product = product_r;

endmodule
